dac_bringup_ctrl: RTL and testbench

Upstream sequencer for the DAC SPI configuration serializer. It runs DAC power-up: it pulses the DAC hardware reset pin, waits for supplies to settle, and releases the serializer's reset. It then gates the serializer with DA_CONTROL, waits for DA_READY, and finally enables the TX data path. It detects a stalled configuration by timeout, retries a bounded number of times, and reports DONE or FAIL to the top level.

---
 rtl/dac_bringup_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_dac_bringup_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_bringup_ctrl.sv
`default_nettype none
// ==========================================================================
// Module : dac_bringup_ctrl
// Brief  : Sequences DAC power-up: chip reset, supply settle and serializer
//          configuration, with timeout and retry. The optional DA_READY
//          deglitch is enabled by defining DAC_READY_DEGLITCH_EN.
// Rev    : 1.0
// ==========================================================================
module dac_bringup_ctrl #(
    parameter int unsigned HWRST_CYCLES  = 64,
    parameter int unsigned PWRUP_WAIT    = 1024,
    parameter int unsigned READY_TIMEOUT = 65535,
    parameter int unsigned SETTLE_WAIT   = 256,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       GCLK,
    input  logic       reset_n,
    input  logic       START,
    input  logic       STOP,
    input  logic       DA_READY,
    output logic       DA_CONTROL,
    output logic       DA_RST,
    output logic       DAC_RESETB,
    output logic       TX_EN,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAIL,
    output logic [3:0] RETRY_CNT
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HWRST   = 3'd1,
        S_PWRWAIT = 3'd2,
        S_SERRST  = 3'd3,
        S_CONFIG  = 3'd4,
        S_SETTLE  = 3'd5,
        S_RUN     = 3'd6,
        S_FAIL    = 3'd7
    } state_t;

    // Counter is cleared on state entry, so a state lasting N cycles exits at N-1.
    localparam logic [15:0] HWRST_LAST   = 16'(HWRST_CYCLES - 1);
    localparam logic [15:0] PWRUP_LAST   = 16'(PWRUP_WAIT - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(READY_TIMEOUT - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_WAIT - 1);
    localparam logic [15:0] SERRST_LAST  = 16'd1;
    localparam logic [3:0]  MAX_RETRY_C  = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  retry_cnt_q, retry_cnt_d;
    logic        da_control_q, da_control_d;
    logic        da_rst_q, da_rst_d;
    logic        dac_resetb_q, dac_resetb_d;
    logic        tx_en_q, tx_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic        ready_ok;

`ifdef DAC_READY_DEGLITCH_EN
    // Number of consecutive high DA_READY samples already seen in CONFIG.
    logic [1:0] rdy_run_q, rdy_run_d;

    always_comb begin
        rdy_run_d = 2'd0;
        if (state_q == S_CONFIG && DA_READY && rdy_run_q != 2'd3) begin
            rdy_run_d = rdy_run_q + 2'd1;
        end
    end

    always_ff @(posedge GCLK or negedge reset_n) begin
        if (!reset_n) begin
            rdy_run_q <= 2'd0;
        end else begin
            rdy_run_q <= rdy_run_d;
        end
    end

    assign ready_ok = DA_READY && (rdy_run_q == 2'd3);
`else
    assign ready_ok = DA_READY;
`endif

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        case (state_q)
            S_IDLE, S_RUN, S_FAIL: begin
                if (START) begin
                    state_d     = S_HWRST;
                    retry_cnt_d = 4'd0;
                end
            end
            S_HWRST:   if (cnt_q == HWRST_LAST)  state_d = S_PWRWAIT;
            S_PWRWAIT: if (cnt_q == PWRUP_LAST)  state_d = S_SERRST;
            S_SERRST:  if (cnt_q == SERRST_LAST) state_d = S_CONFIG;
            S_CONFIG: begin
                if (ready_ok) begin
                    state_d = S_SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_cnt_q < MAX_RETRY_C) begin
                        retry_cnt_d = retry_cnt_q + 4'd1;
                        state_d     = S_HWRST;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_SETTLE:  if (cnt_q == SETTLE_LAST) state_d = S_RUN;
            default:   state_d = S_IDLE;
        endcase
        if (STOP) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        cnt_d = 16'd0;
        if (state_d == state_q &&
            (state_q == S_HWRST || state_q == S_PWRWAIT || state_q == S_SERRST ||
             state_q == S_CONFIG || state_q == S_SETTLE)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Outputs decode the next state so the registered copy lines up with state_q.
    always_comb begin
        da_control_d = 1'b0;
        da_rst_d     = 1'b1;
        dac_resetb_d = 1'b0;
        tx_en_d      = 1'b0;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        fail_d       = 1'b0;
        case (state_d)
            S_IDLE:    busy_d = 1'b0;
            S_HWRST:   busy_d = 1'b1;
            S_PWRWAIT,
            S_SERRST:  dac_resetb_d = 1'b1;
            S_CONFIG: begin
                dac_resetb_d = 1'b1;
                da_rst_d     = 1'b0;
                da_control_d = 1'b1;
            end
            S_SETTLE: begin
                dac_resetb_d = 1'b1;
                da_rst_d     = 1'b0;
            end
            S_RUN: begin
                dac_resetb_d = 1'b1;
                da_rst_d     = 1'b0;
                tx_en_d      = 1'b1;
                busy_d       = 1'b0;
                done_d       = 1'b1;
            end
            S_FAIL: begin
                busy_d = 1'b0;
                fail_d = 1'b1;
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge GCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            retry_cnt_q  <= 4'd0;
            da_control_q <= 1'b0;
            da_rst_q     <= 1'b1;
            dac_resetb_q <= 1'b0;
            tx_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            da_control_q <= da_control_d;
            da_rst_q     <= da_rst_d;
            dac_resetb_q <= dac_resetb_d;
            tx_en_q      <= tx_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    assign DA_CONTROL = da_control_q;
    assign DA_RST     = da_rst_q;
    assign DAC_RESETB = dac_resetb_q;
    assign TX_EN      = tx_en_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign FAIL       = fail_q;
    assign RETRY_CNT  = retry_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_bringup_ctrl.sv
`default_nettype none
// ==========================================================================
// Module : tb_dac_bringup_ctrl
// Brief  : Stimulus queues expected output-change events (cycle + value);
//          a negedge monitor pops and compares on every output change.
// Rev    : 1.0
// ==========================================================================
module tb_dac_bringup_ctrl;

    localparam int HW = 4;
    localparam int PW = 8;
    localparam int TO = 20;
    localparam int ST = 5;
    localparam int MR = 2;
`ifdef DAC_READY_DEGLITCH_EN
    localparam int RDY_N = 4;
`else
    localparam int RDY_N = 1;
`endif

    // {DA_CONTROL, DA_RST, DAC_RESETB, TX_EN, BUSY, DONE, FAIL}
    localparam logic [6:0] F_IDLE   = 7'b0100000;
    localparam logic [6:0] F_HWRST  = 7'b0100100;
    localparam logic [6:0] F_PWR    = 7'b0110100;
    localparam logic [6:0] F_CFG    = 7'b1010100;
    localparam logic [6:0] F_SETTLE = 7'b0010100;
    localparam logic [6:0] F_RUN    = 7'b0011010;
    localparam logic [6:0] F_FAIL   = 7'b0100001;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b1;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       da_ready = 1'b0;
    logic       da_control, da_rst, dac_resetb, tx_en, busy, done, fail_o;
    logic [3:0] retry_cnt;

    dac_bringup_ctrl #(
        .HWRST_CYCLES (HW),
        .PWRUP_WAIT   (PW),
        .READY_TIMEOUT(TO),
        .SETTLE_WAIT  (ST),
        .MAX_RETRY    (MR)
    ) dut (
        .GCLK      (clk),
        .reset_n   (reset_n),
        .START     (start),
        .STOP      (stop),
        .DA_READY  (da_ready),
        .DA_CONTROL(da_control),
        .DA_RST    (da_rst),
        .DAC_RESETB(dac_resetb),
        .TX_EN     (tx_en),
        .BUSY      (busy),
        .DONE      (done),
        .FAIL      (fail_o),
        .RETRY_CNT (retry_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         t;
        logic [10:0] v;
    } ev_t;

    ev_t         exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [10:0] prev_v  = {F_IDLE, 4'd0};
    logic [10:0] cur_v;

    assign cur_v = {da_control, da_rst, dac_resetb, tx_en, busy, done, fail_o, retry_cnt};

    always @(negedge clk) begin
        ev_t e;
        if (cur_v !== prev_v) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change cyc=%0d got=%b (no change expected from %b)",
                         cyc, cur_v, prev_v);
            end else begin
                e = exp_q.pop_front();
                if (e.v !== cur_v || e.t != cyc) begin
                    n_fail++;
                    $display("FAIL %s got=%b at cyc %0d, required=%b at cyc %0d",
                             e.name, cur_v, cyc, e.v, e.t);
                end
            end
            prev_v = cur_v;
        end
    end

    task automatic push(input string nm, input int t, input logic [6:0] f, input logic [3:0] rc);
        ev_t e;
        e.name = nm;
        e.t    = t;
        e.v    = {f, rc};
        exp_q.push_back(e);
    endtask

    task automatic check(input string nm, input logic [10:0] got, input logic [10:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%b required=%b", nm, got, req);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called on a negedge; HWRST is entered on the next posedge.
    task automatic do_start(output int t_hw);
        t_hw = cyc + 1;
        push("start_hwrst", t_hw, F_HWRST, 4'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One attempt from HWRST entry; acc<0 withholds DA_READY, else it is
    // accepted at CONFIG cycle index acc (0 = first CONFIG cycle).
    task automatic attempt(input int t_hw, input int rc, input int acc, output int t_end);
        int t_cf;
        t_cf = t_hw + HW + PW + 2;
        push("pwrwait", t_hw + HW, F_PWR, 4'(rc));
        push("config", t_cf, F_CFG, 4'(rc));
        if (acc < 0) begin
            t_end = t_cf + TO;
            if (rc < MR) push("retry_hwrst", t_end, F_HWRST, 4'(rc + 1));
            else         push("fail_state", t_end, F_FAIL, 4'(rc));
            wait_to(t_end);
        end else begin
            push("settle", t_cf + acc + 1, F_SETTLE, 4'(rc));
            t_end = t_cf + acc + 1 + ST;
            push("run", t_end, F_RUN, 4'(rc));
            wait_to(t_cf + acc - (RDY_N - 1));
            da_ready = 1'b1;
            wait_to(t_cf + acc + 1);
            da_ready = 1'b0;
            wait_to(t_end);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t2;
        int t_cf;
        #1 reset_n = 1'b0;
        #2 check("reset_state", cur_v, {F_IDLE, 4'd0});
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal: ready at CONFIG index 10 -> DA_CONTROL high 11 cycles.
        do_start(t);
        attempt(t, 0, 10, t2);
        repeat (3) @(negedge clk);

        // STOP and START together in RUN: STOP wins.
        push("stop_wins", cyc + 1, F_IDLE, 4'd0);
        stop  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk);

        // Restart; ready accepted on the timeout cycle.
        do_start(t);
        attempt(t, 0, TO - 1, t2);
        @(negedge clk);

        // START in RUN restarts; hung serializer retries then fails.
        do_start(t);
        for (int i = 0; i <= MR; i++) begin
            attempt(t, i, -1, t2);
            t = t2;
        end
        da_ready = 1'b1;
        repeat (3) @(negedge clk);
        da_ready = 1'b0;
        repeat (2) @(negedge clk);

        // From FAIL: ignored START while busy, fail attempt 1, recover on attempt 2.
        do_start(t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        attempt(t, 0, -1, t2);
        attempt(t2, 1, 3, t);
        repeat (2) @(negedge clk);

`ifdef DAC_READY_DEGLITCH_EN
        // 3-cycle pulse rejected, 4-cycle pulse accepted at index 9.
        do_start(t);
        t_cf = t + HW + PW + 2;
        push("dg_pwrwait", t + HW, F_PWR, 4'd0);
        push("dg_config", t_cf, F_CFG, 4'd0);
        push("dg_settle", t_cf + 10, F_SETTLE, 4'd0);
        push("dg_run", t_cf + 10 + ST, F_RUN, 4'd0);
        wait_to(t_cf + 2);
        da_ready = 1'b1;
        wait_to(t_cf + 5);
        da_ready = 1'b0;
        wait_to(t_cf + 6);
        da_ready = 1'b1;
        wait_to(t_cf + 10);
        da_ready = 1'b0;
        wait_to(t_cf + 10 + ST);
        repeat (2) @(negedge clk);
`endif

        // Asynchronous reset in the middle of CONFIG.
        do_start(t);
        t_cf = t + HW + PW + 2;
        push("ar_pwrwait", t + HW, F_PWR, 4'd0);
        push("ar_config", t_cf, F_CFG, 4'd0);
        wait_to(t_cf + 5);
        @(posedge clk);
        #2;
        push("async_reset", cyc, F_IDLE, 4'd0);
        reset_n = 1'b0;
        #1 check("async_reset_immediate", cur_v, {F_IDLE, 4'd0});
        #4 reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_release", cur_v, {F_IDLE, 4'd0});

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events got=%0d required=0 (next: %s)",
                     exp_q.size(), exp_q[0].name);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
